exc_capture_unit: RTL and testbench
===================================

# exc_capture_unit

Parametrised exception capture and stretching unit for the CPU control path. It replaces the fixed one-register hold of BIU fault reports with per-source hold counters of configurable length. It priority-encodes the stretched sources, latches the winning cause and the faulting address, and holds a request to the control FSM until that FSM acknowledges it in its exception state. It sits between the BIU/decoder fault outputs and the interrupt/CSR trap logic.

## Interface
- NSRC, 9: number of exception sources; bit 0 has the highest priority.
- HOLD, 2: cycles each source pulse stays visible; legal range 1..15; 1 means no stretching.
- AW, 32: width of the faulting address.
- CW, 4: cause index width; must satisfy 2^CW >= NSRC.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- exc_in  in  NSRC  raw fault pulses from BIU/decoder.
- addr_in  in  AW  current BIU virtual address, sampled on capture.
- exc_ack  in  1  control FSM has taken the trap (asserted in exc state).
- flush  in  1  discard all pending and stretched exceptions.
- exc_vis  out  NSRC  stretched per-source view.
- exc_any  out  1  OR of exc_vis; combinational, for FSM next-state decisions.
- exc_req  out  1  captured exception pending.
- exc_cause  out  CW  index of the captured source.
- exc_tval  out  AW  address latched with the capture.
- exc_lost  out  1  sticky flag: another exception arrived while one was pending.

## Operation
- Stretch: each source has a counter cnt[i] of 4 bits.
  - exc_in[i]=1 loads HOLD-1.
  - Otherwise a nonzero cnt[i] decrements.
  - exc_vis[i] = exc_in[i] | (cnt[i]!=0).
- FSM has two states.
  - IDLE: if exc_vis != 0, capture the lowest set index into exc_cause and addr_in into exc_tval, then go to PEND.
  - PEND: exc_req=1. Capture registers are frozen. On exc_ack, go to IDLE and clear all cnt.
- exc_ack in IDLE is ignored.
- exc_in asserted in the same cycle as exc_ack still loads its counter, so it is seen in IDLE next cycle and captured then. Stale stretched pulses from before the ack are dropped.
- flush has top priority in every state:
  - cnt, exc_req and exc_lost clear; state goes to IDLE.
  - exc_in in the flush cycle is dropped.
  - exc_cause and exc_tval hold their values.
- exc_lost (when enabled) is set in PEND if any exc_in bit is 1 in a cycle other than the capture cycle. It clears on exc_ack or flush.
- Simultaneous sources in IDLE: lowest index wins; the others remain visible in exc_vis until their counters expire or the ack arrives.

## Timing
- Reset values:
  - exc_vis=0, exc_any=0, exc_req=0, exc_cause=0, exc_tval=0, exc_lost=0.
  - All cnt=0; state IDLE.
- exc_in at cycle t:
  - exc_vis and exc_any high at t, combinationally.
  - exc_req, exc_cause and exc_tval valid from t+1.
- A single-cycle pulse remains in exc_vis for cycles t..t+HOLD-1.
- exc_ack at cycle t: exc_req low at t+1. Earliest new exc_req is t+2.
- rst mid-PEND: all state returns to reset values at the next edge; the pending trap is lost.

## Configuration
- EXC_LOST_TRACK_EN
  - Defined: exc_lost is implemented as described.
  - Undefined: exc_lost is tied to 0 and no tracking logic is built.

## Test plan
- HOLD=2, exc_in=9'b000000100 for one cycle at t, addr_in=32'h8000_1004:
  - exc_vis[2] high for t and t+1.
  - exc_req=1 at t+1 with exc_cause=2, exc_tval=32'h8000_1004.
- exc_in=9'b000101000 in one cycle: exc_cause=3; exc_vis[5] stays high for HOLD cycles.
- In PEND, pulse exc_in[0]:
  - exc_cause is unchanged.
  - With EXC_LOST_TRACK_EN, exc_lost=1 until exc_ack; without it, exc_lost stays 0.
- exc_ack together with exc_in[7]=1:
  - exc_req=0 at t+1.
  - exc_req=1 at t+2 with exc_cause=7.
- flush together with exc_in[1] while in PEND:
  - exc_req=0 and exc_vis=0 at t+1.
  - exc_cause keeps its old value; no new capture follows.
- HOLD=1:
  - A one-cycle pulse is visible for exactly one cycle.
  - rst asserted in PEND returns all outputs to 0.

Source files
------------

// File: rtl/exc_capture_if.sv
// Exception capture bus: raw fault sources and trap handshake toward the control FSM.
// The master side drives the faults, the address, the acknowledge and the flush.
interface exc_capture_if #(
   parameter int NSRC = 9,
   parameter int AW   = 32,
   parameter int CW   = 4
);
   logic [NSRC-1:0] exc_in;
   logic [AW-1:0]   addr_in;
   logic            exc_ack;
   logic            flush;
   logic [NSRC-1:0] exc_vis;
   logic            exc_any;
   logic            exc_req;
   logic [CW-1:0]   exc_cause;
   logic [AW-1:0]   exc_tval;
   logic            exc_lost;

   modport master (
      output exc_in, addr_in, exc_ack, flush,
      input  exc_vis, exc_any, exc_req, exc_cause, exc_tval, exc_lost
   );

   modport slave (
      input  exc_in, addr_in, exc_ack, flush,
      output exc_vis, exc_any, exc_req, exc_cause, exc_tval, exc_lost
   );
endinterface

// File: rtl/exc_capture_unit.sv
// Exception capture unit: per-source pulse stretching, priority capture of cause/address,
// trap request held until acknowledged. Optional lost-exception flag: EXC_LOST_TRACK_EN.
module exc_capture_unit #(
   parameter int NSRC = 9,
   parameter int HOLD = 2,
   parameter int AW   = 32,
   parameter int CW   = 4
) (
   input  logic         clk,
   input  logic         rst,
   exc_capture_if.slave bus
);
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

   localparam logic [3:0] HOLD_LD = 4'(HOLD - 1);

   state_t        state_r;
   logic [3:0]    cnt_r [NSRC];
   logic [NSRC-1:0] vis_s;
   logic          ack_pend_s;
   logic          req_r;
   logic [CW-1:0] cause_r;
   logic [AW-1:0] tval_r;

   function automatic logic [CW-1:0] lowest_idx(input logic [NSRC-1:0] v);
      logic [CW-1:0] idx;
      idx = {CW{1'b0}};
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = CW'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   assign ack_pend_s = (state_r == ST_PEND) & bus.exc_ack;

   // Stretched view: a live pulse or a still-running hold counter.
   always_comb begin
      vis_s = {NSRC{1'b0}};
      for (int i = 0; i < NSRC; i++) begin
         vis_s[i] = bus.exc_in[i] | (cnt_r[i] != 4'd0);
      end
   end

   // Hold counters; an acknowledge drops stale stretch but keeps same-cycle pulses.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NSRC; i++) begin
         if (rst || bus.flush) begin
            cnt_r[i] <= 4'd0;
         end else if (bus.exc_in[i]) begin
            cnt_r[i] <= HOLD_LD;
         end else if (ack_pend_s || (cnt_r[i] == 4'd0)) begin
            cnt_r[i] <= 4'd0;
         end else begin
            cnt_r[i] <= cnt_r[i] - 4'd1;
         end
      end
   end

   // Capture FSM; cause and address stay frozen while a trap is pending or flushed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         req_r   <= 1'b0;
         cause_r <= {CW{1'b0}};
         tval_r  <= {AW{1'b0}};
      end else if (bus.flush) begin
         state_r <= ST_IDLE;
         req_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (|vis_s) begin
                  state_r <= ST_PEND;
                  req_r   <= 1'b1;
                  cause_r <= lowest_idx(vis_s);
                  tval_r  <= bus.addr_in;
               end else begin
                  state_r <= ST_IDLE;
                  req_r   <= 1'b0;
               end
            end
            ST_PEND: begin
               if (bus.exc_ack) begin
                  state_r <= ST_IDLE;
                  req_r   <= 1'b0;
               end else begin
                  state_r <= ST_PEND;
                  req_r   <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               req_r   <= 1'b0;
            end
         endcase
      end
   end

`ifdef EXC_LOST_TRACK_EN
   logic lost_r;

   // Sticky overrun flag: any new fault seen while a trap waits for service.
   always_ff @(posedge clk) begin
      if (rst || bus.flush || ack_pend_s) begin
         lost_r <= 1'b0;
      end else if ((state_r == ST_PEND) && (|bus.exc_in)) begin
         lost_r <= 1'b1;
      end else begin
         lost_r <= lost_r;
      end
   end

   assign bus.exc_lost = lost_r;
`else
   assign bus.exc_lost = 1'b0;
`endif

   assign bus.exc_vis   = vis_s;
   assign bus.exc_any   = |vis_s;
   assign bus.exc_req   = req_r;
   assign bus.exc_cause = cause_r;
   assign bus.exc_tval  = tval_r;
endmodule

// File: tb/tb_exc_capture_unit.sv
// Bench for exc_capture_unit: HOLD=2 and HOLD=1 instances share stimulus and are checked
// every cycle against an event-time model, plus directed literal expectations.
module tb_exc_capture_unit;
   localparam int NSRC = 9;
   localparam int AW   = 32;
   localparam int CW   = 4;
`ifdef EXC_LOST_TRACK_EN
   localparam bit LOST_EN = 1'b1;
`else
   localparam bit LOST_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NSRC-1:0] exc_in = '0;
   logic [AW-1:0]   addr_in = '0;
   logic exc_ack = 1'b0;
   logic flush = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   exc_capture_if #(.NSRC(NSRC), .AW(AW), .CW(CW)) bus0 ();
   exc_capture_if #(.NSRC(NSRC), .AW(AW), .CW(CW)) bus1 ();

   assign bus0.exc_in = exc_in;  assign bus1.exc_in = exc_in;
   assign bus0.addr_in = addr_in; assign bus1.addr_in = addr_in;
   assign bus0.exc_ack = exc_ack; assign bus1.exc_ack = exc_ack;
   assign bus0.flush = flush;    assign bus1.flush = flush;

   exc_capture_unit #(.NSRC(NSRC), .HOLD(2), .AW(AW), .CW(CW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   exc_capture_unit #(.NSRC(NSRC), .HOLD(1), .AW(AW), .CW(CW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Model: each source remembers the cycle of its last accepted pulse.
   int cyc = 0;
   int mlast [2][NSRC];
   bit mpend [2];
   logic [CW-1:0] mcause [2];
   logic [AW-1:0] mtval [2];
   bit mlost [2];

   function automatic int hold_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic logic [NSRC-1:0] mvis(input int k);
      logic [NSRC-1:0] v;
      for (int i = 0; i < NSRC; i++)
         v[i] = exc_in[i] || ((cyc - mlast[k][i]) <= (hold_of(k) - 1));
      return v;
   endfunction

   function automatic logic [CW-1:0] lowest(input logic [NSRC-1:0] v);
      for (int i = 0; i < NSRC; i++)
         if (v[i]) return CW'(i);
      return '0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NSRC; i++) mlast[k][i] = -100;
         mpend[k] = 1'b0; mcause[k] = '0; mtval[k] = '0; mlost[k] = 1'b0;
      end
   end

   // Model update at each active edge from the inputs of the cycle just ending.
   always @(posedge clk) begin : model
      logic [NSRC-1:0] v;
      for (int k = 0; k < 2; k++) begin
         v = mvis(k);
         if (rst) begin
            mpend[k] = 1'b0; mcause[k] = '0; mtval[k] = '0; mlost[k] = 1'b0;
            for (int i = 0; i < NSRC; i++) mlast[k][i] = -100;
         end else if (flush) begin
            mpend[k] = 1'b0; mlost[k] = 1'b0;
            for (int i = 0; i < NSRC; i++) mlast[k][i] = -100;
         end else if (!mpend[k]) begin
            if (v != '0) begin
               mpend[k] = 1'b1; mcause[k] = lowest(v); mtval[k] = addr_in;
            end
            for (int i = 0; i < NSRC; i++) if (exc_in[i]) mlast[k][i] = cyc;
         end else if (exc_ack) begin
            mpend[k] = 1'b0; mlost[k] = 1'b0;
            for (int i = 0; i < NSRC; i++) mlast[k][i] = exc_in[i] ? cyc : -100;
         end else begin
            if (exc_in != '0 && LOST_EN) mlost[k] = 1'b1;
            for (int i = 0; i < NSRC; i++) if (exc_in[i]) mlast[k][i] = cyc;
         end
      end
      cyc = cyc + 1;
   end

   // Compare process: both DUTs against the model on every falling edge.
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("vis0", 64'(bus0.exc_vis), 64'(mvis(0)));
         chk("any0", 64'(bus0.exc_any), 64'(|mvis(0)));
         chk("req0", 64'(bus0.exc_req), 64'(mpend[0]));
         chk("cause0", 64'(bus0.exc_cause), 64'(mcause[0]));
         chk("tval0", 64'(bus0.exc_tval), 64'(mtval[0]));
         chk("lost0", 64'(bus0.exc_lost), 64'(mlost[0]));
         chk("vis1", 64'(bus1.exc_vis), 64'(mvis(1)));
         chk("any1", 64'(bus1.exc_any), 64'(|mvis(1)));
         chk("req1", 64'(bus1.exc_req), 64'(mpend[1]));
         chk("cause1", 64'(bus1.exc_cause), 64'(mcause[1]));
         chk("tval1", 64'(bus1.exc_tval), 64'(mtval[1]));
         chk("lost1", 64'(bus1.exc_lost), 64'(mlost[1]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick(); tick();
      #1;
      chk("rst_req", 64'(bus0.exc_req), 64'd0);
      chk("rst_vis", 64'(bus0.exc_vis), 64'd0);
      chk("rst_cause", 64'(bus0.exc_cause), 64'd0);
      chk("rst_tval", 64'(bus0.exc_tval), 64'd0);
      chk("rst_lost", 64'(bus0.exc_lost), 64'd0);
      rst = 1'b0;

      // Single pulse on source 2 with HOLD=2.
      tick(); exc_in = 9'b000000100; addr_in = 32'h8000_1004; #1;
      chk("a_vis_t", 64'(bus0.exc_vis), 64'h004);
      chk("a_any_t", 64'(bus0.exc_any), 64'd1);
      chk("a_req_t", 64'(bus0.exc_req), 64'd0);
      tick(); exc_in = '0; #1;
      chk("a_vis_t1", 64'(bus0.exc_vis), 64'h004);
      chk("a_req_t1", 64'(bus0.exc_req), 64'd1);
      chk("a_cause", 64'(bus0.exc_cause), 64'd2);
      chk("a_tval", 64'(bus0.exc_tval), 64'h8000_1004);
      chk("a_model_cause", 64'(mcause[0]), 64'd2);
      tick(); #1;
      chk("a_vis_t2", 64'(bus0.exc_vis), 64'h000);
      chk("a_req_t2", 64'(bus0.exc_req), 64'd1);

      // New pulse while pending.
      exc_in = 9'b000000001;
      tick(); exc_in = '0; #1;
      chk("p_cause", 64'(bus0.exc_cause), 64'd2);
      chk("p_lost", 64'(bus0.exc_lost), 64'(LOST_EN));

      // Acknowledge together with a fresh source 7 pulse.
      exc_ack = 1'b1; exc_in = 9'b010000000; addr_in = 32'h0000_2000;
      tick(); exc_ack = 1'b0; exc_in = '0; #1;
      chk("k_req_t1", 64'(bus0.exc_req), 64'd0);
      chk("k_lost_t1", 64'(bus0.exc_lost), 64'd0);
      tick(); #1;
      chk("k_req_t2", 64'(bus0.exc_req), 64'd1);
      chk("k_cause_t2", 64'(bus0.exc_cause), 64'd7);
      exc_ack = 1'b1;
      tick(); exc_ack = 1'b0;

      // Two simultaneous sources: lowest index wins.
      exc_in = 9'b000101000;
      tick(); exc_in = '0; #1;
      chk("s_cause", 64'(bus0.exc_cause), 64'd3);
      chk("s_req", 64'(bus0.exc_req), 64'd1);
      chk("s_vis5", 64'(bus0.exc_vis[5]), 64'd1);
      tick(); #1;
      chk("s_vis_end", 64'(bus0.exc_vis), 64'd0);

      // Flush with a pulse while pending.
      flush = 1'b1; exc_in = 9'b000000010;
      tick(); flush = 1'b0; exc_in = '0; #1;
      chk("f_req", 64'(bus0.exc_req), 64'd0);
      chk("f_vis", 64'(bus0.exc_vis), 64'd0);
      chk("f_cause", 64'(bus0.exc_cause), 64'd3);
      tick(); #1;
      chk("f_nocap", 64'(bus0.exc_req), 64'd0);

      // HOLD=1 instance: no stretching, then reset while pending.
      exc_in = 9'b000010000; #1;
      chk("h1_vis_t", 64'(bus1.exc_vis), 64'h010);
      tick(); exc_in = '0; #1;
      chk("h1_vis_t1", 64'(bus1.exc_vis), 64'h000);
      chk("h1_req", 64'(bus1.exc_req), 64'd1);
      chk("h1_cause", 64'(bus1.exc_cause), 64'd4);
      rst = 1'b1;
      tick(); rst = 1'b0; #1;
      chk("r_req", 64'(bus1.exc_req), 64'd0);
      chk("r_cause", 64'(bus1.exc_cause), 64'd0);
      chk("r_tval", 64'(bus1.exc_tval), 64'd0);
      chk("r_vis", 64'(bus1.exc_vis), 64'd0);
      chk("r_any", 64'(bus1.exc_any), 64'd0);
      chk("r_lost", 64'(bus1.exc_lost), 64'd0);

      // Randomized traffic.
      for (int n = 0; n < 2000; n++) begin
         tick();
         rst     = ($urandom_range(0, 99) == 0);
         flush   = ($urandom_range(0, 31) == 0);
         exc_ack = ($urandom_range(0, 4) == 0);
         exc_in  = ($urandom_range(0, 3) == 0) ? (NSRC'($urandom) & NSRC'($urandom)) : '0;
         addr_in = $urandom;
      end
      tick();
      rst = 1'b0; flush = 1'b0; exc_ack = 1'b0; exc_in = '0;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
